// File: rtl/lif_tdm_scheduler_if.sv
// Bundle of the run-enable, stimulus-write and update-result signals of
// lif_tdm_scheduler. The slave modport is the scheduler; the master modport
// is whoever drives stimulus and consumes results.
// Optional macro LIF_SPIKE_COUNT_EN adds the spike-counter read port.
interface lif_tdm_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int W         = 8
);
  localparam int IW = $clog2(N_NEURONS);

  logic          en;
  logic          stim_valid;
  logic [IW-1:0] stim_idx;
  logic [W-1:0]  stim_val;
  logic          stim_ready;
  logic          v_valid;
  logic [IW-1:0] v_idx;
  logic [W-1:0]  v_mem;
  logic          spike;
  logic          sweep_done;
`ifdef LIF_SPIKE_COUNT_EN
  logic [IW-1:0] cnt_idx;
  logic [7:0]    cnt_out;

  modport master (
    output en, stim_valid, stim_idx, stim_val, cnt_idx,
    input  stim_ready, v_valid, v_idx, v_mem, spike, sweep_done, cnt_out
  );
  modport slave (
    input  en, stim_valid, stim_idx, stim_val, cnt_idx,
    output stim_ready, v_valid, v_idx, v_mem, spike, sweep_done, cnt_out
  );
`else
  modport master (
    output en, stim_valid, stim_idx, stim_val,
    input  stim_ready, v_valid, v_idx, v_mem, spike, sweep_done
  );
  modport slave (
    input  en, stim_valid, stim_idx, stim_val,
    output stim_ready, v_valid, v_idx, v_mem, spike, sweep_done
  );
`endif
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Time-division leaky-integrate-and-fire scheduler: one shared update
// datapath sweeps N_NEURONS virtual neurons round-robin, one per enabled
// cycle, with per-neuron membrane, pending-input and refractory state.
// Optional macro LIF_SPIKE_COUNT_EN adds saturating 8-bit per-neuron spike
// counters readable through cnt_idx/cnt_out.
module lif_tdm_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int THRESH     = 200,
  parameter int REFRAC     = 4
) (
  input logic                clk,
  input logic                reset,
  lif_tdm_scheduler_if.slave bus
);
  localparam int            IW       = $clog2(N_NEURONS);
  localparam logic [W-1:0]  THRESH_C = W'(THRESH);
  localparam logic [3:0]    REFRAC_C = 4'(REFRAC);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);

  logic [W-1:0]  v_q    [N_NEURONS];
  logic [W-1:0]  v_d    [N_NEURONS];
  logic [W-1:0]  pend_q [N_NEURONS];
  logic [W-1:0]  pend_d [N_NEURONS];
  logic [3:0]    rcnt_q [N_NEURONS];
  logic [3:0]    rcnt_d [N_NEURONS];
  logic [IW-1:0] ptr_q, ptr_d;

  logic          v_valid_q, spike_q, sweep_done_q;
  logic [IW-1:0] v_idx_q;
  logic [W-1:0]  v_mem_q;

  logic          accept;
  logic          refractory;
  logic          fire;
  logic [W-1:0]  v_p, pend_p, leak;
  logic [W:0]    sum_raw;
  logic [W-1:0]  sum_sat;
  logic [W-1:0]  new_v;
  logic [W:0]    add_raw;

  assign bus.stim_ready = bus.en;
  assign accept         = bus.en & bus.stim_valid;

  // Shared datapath: leak, integrate and threshold the neuron under ptr.
  // V - leak never underflows, so W+1 bits hold the sum without wrap.
  assign v_p        = v_q[ptr_q];
  assign pend_p     = pend_q[ptr_q];
  assign leak       = v_p >> LEAK_SHIFT;
  assign sum_raw    = {1'b0, v_p} - {1'b0, leak} + {1'b0, pend_p};
  assign sum_sat    = sum_raw[W] ? '1 : sum_raw[W-1:0];
  assign refractory = (rcnt_q[ptr_q] != 4'd0);
  assign fire       = !refractory && (sum_sat >= THRESH_C);
  assign new_v      = (refractory || fire) ? '0 : sum_sat;

  // Next-state for the neuron array: consume pend of the visited neuron
  // first, then merge the accepted stimulus, so a same-cycle write to the
  // visited neuron lands in its now-empty pend and is used next visit.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves a variable unassigned and no latch is inferred.
    v_d     = v_q;
    pend_d  = pend_q;
    rcnt_d  = rcnt_q;
    ptr_d   = ptr_q;
    add_raw = '0;
    if (bus.en) begin
      v_d[ptr_q]    = new_v;
      pend_d[ptr_q] = '0;
      if (refractory) begin
        rcnt_d[ptr_q] = rcnt_q[ptr_q] - 4'd1;
      end else if (fire) begin
        rcnt_d[ptr_q] = REFRAC_C;
      end
      ptr_d = ptr_q + 1'b1;  // power-of-two count wraps naturally
    end
    if (accept) begin
      add_raw                = {1'b0, pend_d[bus.stim_idx]} + {1'b0, bus.stim_val};
      pend_d[bus.stim_idx]   = add_raw[W] ? '1 : add_raw[W-1:0];
    end
  end

  // State registers and the registered result of this cycle's update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the neuron arrays are small register files that must start at
      // zero, so they are reset like any other state; sequential logic uses
      // non-blocking assignments throughout.
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]    <= '0;
        pend_q[i] <= '0;
        rcnt_q[i] <= '0;
      end
      ptr_q        <= '0;
      v_valid_q    <= 1'b0;
      v_idx_q      <= '0;
      v_mem_q      <= '0;
      spike_q      <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      v_q       <= v_d;
      pend_q    <= pend_d;
      rcnt_q    <= rcnt_d;
      ptr_q     <= ptr_d;
      v_valid_q <= bus.en;
      if (bus.en) begin
        v_idx_q      <= ptr_q;
        v_mem_q      <= new_v;
        spike_q      <= fire;
        sweep_done_q <= (ptr_q == LAST_IDX);
      end else begin
        spike_q      <= 1'b0;
        sweep_done_q <= 1'b0;
      end
    end
  end

  assign bus.v_valid    = v_valid_q;
  assign bus.v_idx      = v_idx_q;
  assign bus.v_mem      = v_mem_q;
  assign bus.spike      = spike_q;
  assign bus.sweep_done = sweep_done_q;

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] cnt_q [N_NEURONS];

  // Per-neuron spike counters, saturating at 255, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) cnt_q[i] <= '0;
    end else if (bus.en && fire && (cnt_q[ptr_q] != 8'hFF)) begin
      cnt_q[ptr_q] <= cnt_q[ptr_q] + 8'd1;
    end
  end

  assign bus.cnt_out = cnt_q[bus.cnt_idx];
`endif

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Self-checking bench for lif_tdm_scheduler: directed scenarios followed by
// randomized stimulus, all compared against an integer reference model of
// the neuron rules. Honours LIF_SPIKE_COUNT_EN when defined.
module tb_lif_tdm_scheduler;
  localparam int N      = 4;
  localparam int W      = 8;
  localparam int IW     = $clog2(N);
  localparam int LS     = 3;
  localparam int THRESH = 200;
  localparam int REFRAC = 4;
  localparam int MAXV   = (1 << W) - 1;

  logic clk;
  logic reset;

  lif_tdm_scheduler_if #(.N_NEURONS(N), .W(W)) bus ();

  lif_tdm_scheduler #(
    .N_NEURONS(N), .W(W), .LEAK_SHIFT(LS), .THRESH(THRESH), .REFRAC(REFRAC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_v   [N];
  int m_p   [N];
  int m_r   [N];
  int m_cnt [N];
  int m_ptr;

  // Last observed result.
  int obs_valid, obs_idx, obs_mem, obs_spike;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_p[i] = 0; m_r[i] = 0; m_cnt[i] = 0;
    end
    m_ptr = 0;
    obs_valid = 0; obs_idx = 0; obs_mem = 0; obs_spike = 0;
  endtask

  // One clock cycle: drive inputs, advance the model, compare results.
  task automatic step(input logic en, input logic sv, input int si, input int sval);
    int p, leak, sum, e_mem, e_spike, ci;
    p = m_ptr; e_mem = 0; e_spike = 0;
    bus.en         = en;
    bus.stim_valid = sv;
    bus.stim_idx   = IW'(si);
    bus.stim_val   = W'(sval);
    ci = int'($urandom_range(N - 1));
`ifdef LIF_SPIKE_COUNT_EN
    bus.cnt_idx = IW'(ci);
`endif
    #1;
    check("stim_ready", {31'd0, bus.stim_ready}, {31'd0, en});
    if (en) begin
      leak = m_v[p] >> LS;
      sum  = m_v[p] - leak + m_p[p];
      if (sum > MAXV) sum = MAXV;
      m_p[p] = 0;
      if (m_r[p] > 0) begin
        m_r[p]--;
      end else if (sum >= THRESH) begin
        e_spike = 1;
        m_r[p]  = REFRAC;
        if (m_cnt[p] < 255) m_cnt[p]++;
      end else begin
        e_mem = sum;
      end
      m_v[p] = e_mem;
      m_ptr  = (m_ptr + 1) % N;
      if (sv) begin
        m_p[si] = m_p[si] + sval;
        if (m_p[si] > MAXV) m_p[si] = MAXV;
      end
    end
    @(posedge clk);
    #1;
    obs_valid = int'(bus.v_valid);
    obs_idx   = int'(bus.v_idx);
    obs_mem   = int'(bus.v_mem);
    obs_spike = int'(bus.spike);
    check("v_valid", {31'd0, bus.v_valid}, {31'd0, en});
    if (en) begin
      check("v_idx", 32'(bus.v_idx), 32'(p));
      check("v_mem", 32'(bus.v_mem), 32'(e_mem));
      check("spike", {31'd0, bus.spike}, 32'(e_spike));
      check("sweep_done", {31'd0, bus.sweep_done}, 32'(p == N - 1));
    end else begin
      check("spike_frozen", {31'd0, bus.spike}, 32'd0);
      check("sweep_frozen", {31'd0, bus.sweep_done}, 32'd0);
    end
`ifdef LIF_SPIKE_COUNT_EN
    check("cnt_out", 32'(bus.cnt_out), 32'(m_cnt[ci]));
`endif
  endtask

  // Run enabled idle cycles until neuron idx has just been reported.
  task automatic run_until(input int idx);
    int n = 0;
    do begin
      step(1'b1, 1'b0, 0, 0);
      n++;
    end while (!(obs_valid == 1 && obs_idx == idx) && n < 64);
    check("reach_idx", 32'(obs_idx), 32'(idx));
  endtask

  // Stimulus write that avoids colliding with the neuron being visited.
  task automatic stim_nc(input int idx, input int val);
    int g = 0;
    while (m_ptr == idx && g < 4) begin
      step(1'b1, 1'b0, 0, 0);
      g++;
    end
    step(1'b1, 1'b1, idx, val);
  endtask

  // Assert reset between clock edges and check outputs clear immediately.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_v_valid", {31'd0, bus.v_valid}, 32'd0);
    check("rst_v_idx", 32'(bus.v_idx), 32'd0);
    check("rst_v_mem", 32'(bus.v_mem), 32'd0);
    check("rst_spike", {31'd0, bus.spike}, 32'd0);
    check("rst_sweep", {31'd0, bus.sweep_done}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int save_ptr, v1, e1;
    reset = 1'b1;
    bus.en = 1'b0; bus.stim_valid = 1'b0; bus.stim_idx = '0; bus.stim_val = '0;
`ifdef LIF_SPIKE_COUNT_EN
    bus.cnt_idx = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_v_valid", {31'd0, bus.v_valid}, 32'd0);
    reset = 1'b0;

    // Reset mid-run with pending stimulus; sweep restarts at neuron 0.
    step(1'b1, 1'b1, 2, 120);
    step(1'b1, 1'b1, 3, 90);
    mid_reset();
    step(1'b1, 1'b0, 0, 0);
    check("rst_first_idx", 32'(obs_idx), 32'd0);
    check("rst_first_mem", 32'(obs_mem), 32'd0);

    // Integration and leak on neuron 1 (ptr is 1 here).
    step(1'b1, 1'b0, 0, 0);
    stim_nc(1, 100);
    run_until(1);
    check("int_100", 32'(obs_mem), 32'd100);
    run_until(1);
    check("leak_88", 32'(obs_mem), 32'd88);
    run_until(1);
    check("leak_77", 32'(obs_mem), 32'd77);

    // Threshold and refractory window on neuron 2.
    stim_nc(2, 250);
    run_until(2);
    check("thr_spike", 32'(obs_spike), 32'd1);
    check("thr_mem", 32'(obs_mem), 32'd0);
    for (int k = 0; k < REFRAC; k++) begin
      stim_nc(2, 250);
      run_until(2);
      check("refr_spike", 32'(obs_spike), 32'd0);
      check("refr_mem", 32'(obs_mem), 32'd0);
    end
    stim_nc(2, 250);
    run_until(2);
    check("refr_end_spike", 32'(obs_spike), 32'd1);

    // Accumulation on neuron 0, saturation on neuron 3.
    run_until(0);
    stim_nc(0, 60);
    stim_nc(0, 70);
    run_until(0);
    check("acc_130", 32'(obs_mem), 32'd130);
    stim_nc(3, 200);
    stim_nc(3, 100);
    run_until(3);
    check("sat_spike", 32'(obs_spike), 32'd1);

    // Collision: stimulus to neuron 1 while it is being visited.
    run_until(0);
    v1 = m_v[1];
    e1 = v1 - (v1 >> LS);
    step(1'b1, 1'b1, 1, 50);
    check("coll_now", 32'(obs_mem), 32'(e1));
    run_until(1);
    check("coll_next", 32'(obs_mem), 32'(e1 - (e1 >> LS) + 50));

    // Enable gating: freeze for 10 cycles with stims offered.
    save_ptr = m_ptr;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, int'($urandom_range(N - 1)), 250);
    end
    step(1'b1, 1'b0, 0, 0);
    check("resume_idx", 32'(obs_idx), 32'(save_ptr));

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(99) == 0) begin
        mid_reset();
      end else begin
        step(logic'($urandom_range(99) < 85), logic'($urandom_range(1)),
             int'($urandom_range(N - 1)), int'($urandom_range(MAXV)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lif_tdm_scheduler.md
Name: lif_tdm_scheduler

Overview:
Time-division scheduler that shares one leaky-integrate-and-fire update datapath across N_NEURONS virtual neurons.
- Keeps per-neuron membrane, pending-input and refractory state in registers.
- Accepts synaptic stimulus writes addressed to any neuron.
- Sweeps the neurons round-robin, one update per enabled cycle.
- Reports membrane values and spikes for the top-level wrapper to drive onto uo_out/uio_out.

Parameters:
N_NEURONS, 4, number of virtual neurons; power of two, 2..16.
W, 8, membrane/current width in bits.
LEAK_SHIFT, 3, leak = V >> LEAK_SHIFT per visit.
THRESH, 200, spike threshold; unsigned, W bits.
REFRAC, 4, number of visits a neuron stays refractory after a spike; 0..15.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
en  in  1  run enable (driven from ena); 0 = freeze.
stim_valid  in  1  stimulus write request.
stim_idx  in  IW=$clog2(N_NEURONS)  target neuron.
stim_val  in  W  synaptic current to add.
stim_ready  out  1  combinational, equal to en; a write is accepted when stim_valid && stim_ready.
v_valid  out  1  one-cycle pulse: an update result is on v_idx/v_mem.
v_idx  out  IW  neuron just updated.
v_mem  out  W  post-update membrane value of v_idx.
spike  out  1  one-cycle pulse, qualified by v_valid.
sweep_done  out  1  pulse with v_valid when v_idx == N_NEURONS-1.

Behaviour:
- Reset (async): ptr=0; every V, pending and refrac_cnt = 0; all outputs 0.
- State per neuron n: V[n] (W bits), pend[n] (W bits), rcnt[n] (4 bits). Global ptr (IW bits).
- en=0: ptr, V, pend and rcnt hold; v_valid/spike/sweep_done = 0; stims are not accepted.
- en=1, each cycle, neuron p=ptr is processed:
  - leak = V[p] >> LEAK_SHIFT.
  - sum = V[p] - leak + pend[p], computed in W+1 bits and saturated to 2^W-1.
  - If rcnt[p] != 0: V[p] <= 0, rcnt[p] <= rcnt[p]-1, pend[p] discarded, no spike.
  - Else if sum >= THRESH: spike, V[p] <= 0, rcnt[p] <= REFRAC.
  - Else: V[p] <= sum.
  - ptr <= ptr+1, wrapping N_NEURONS-1 -> 0.
- Output latency: results are registered. v_valid, v_idx=p, v_mem=new V[p], spike and sweep_done appear in the cycle after p is processed. v_mem is 0 on a spike cycle.
- Stimulus accept: pend[stim_idx] <= pend[stim_idx] + stim_val, saturating at 2^W-1.
- Collision (stim_idx == ptr in the same cycle): the old pend[p] is consumed by the update. pend[p] is then loaded with stim_val, so the stimulus is applied on the next visit and is never lost.
- Stimulus to a refractory neuron is accepted into pend, but is discarded if it is consumed while rcnt != 0.
- Reset asserted mid-sweep: all state clears immediately; the first update after release is neuron 0.
- Throughput: one neuron per enabled cycle; a full sweep takes N_NEURONS cycles.

Optional Feature:
Macro LIF_SPIKE_COUNT_EN.
- Defined:
  - Adds ports cnt_idx (in, IW) and cnt_out (out, 8). cnt_out is a combinational read of an 8-bit per-neuron spike counter.
  - A counter increments on each spike of its neuron and saturates at 255.
  - Counters clear on reset only.
- Not defined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Reset: assert reset mid-run with pending stims -> all outputs 0 at once. After release with en=1, first v_valid has v_idx=0, v_mem=0.
2. Integration and leak: stim 100 to neuron 1 -> its next visit gives v_mem=100; following visits with no stim give 88, then 77 (leak >>3).
3. Threshold and refractory: stim 250 to neuron 2 -> v_valid with v_idx=2, spike=1, v_mem=0. Stims of 250 on each of the next 4 visits -> v_mem=0 with no spike. The 5th stim of 250 produces a spike again.
4. Accumulate and saturate: stims 60 and 70 to neuron 0 within one sweep -> v_mem=130. Stims 200 and 100 to neuron 3 -> pend saturates to 255 -> spike.
5. Collision: stim 50 to neuron 1 in the cycle ptr=1 -> this visit shows only prior state. The next visit of neuron 1 includes +50.
6. Enable gating: drop en for 10 cycles -> no v_valid, stim_ready=0, stims ignored, ptr unchanged. The sweep resumes at the same neuron.
